// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//
// Purpose : Shared types and sizing helpers for the bit-serial subtractor.
//           The state enum is the single source of truth for the FSM
//           encoding. The top module mirrors it into plain localparam
//           constants so the state register stays a simple logic vector
//           that legacy tools and waveform viewers can handle.
//
// Contents:
//   state_e    - FSM states IDLE / RUN / DONE
//   STATE_W    - width of the state register
//   cnt_width  - bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH, so it is sized for WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//
// Purpose : Groups the request and result handshakes of the serial
//           subtractor into one bundle. The master side issues operands and
//           consumes results. The slave side is the subtractor itself.
//
// Parameters:
//   WIDTH     - operand / result width in bits
//
// Signals:
//   in_valid  - request valid            (master -> slave)
//   in_ready  - request can be accepted  (slave  -> master)
//   a, b      - minuend / subtrahend     (master -> slave)
//   out_valid - result valid             (slave  -> master)
//   out_ready - result accepted          (master -> slave)
//   diff      - (a - b) mod 2^WIDTH      (slave  -> master)
//   borrow    - 1 iff a < b unsigned     (slave  -> master)
//   ovf       - signed overflow flag     (slave  -> master)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow,
    output ovf
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
//
// Purpose : One-bit half subtractor, the subtracting counterpart of the
//           half-adder cell. It computes x - y without an incoming borrow.
//           Two of these cells plus an OR gate form a full-subtract step.
//
// Ports:
//   x  - minuend bit
//   y  - subtrahend bit
//   d  - difference bit  (x ^ y)
//   bo - borrow out      (~x & y)
// -----------------------------------------------------------------------------
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Purpose : Bit-serial WIDTH-bit subtractor. It computes diff = a - b one bit
//           per clock, LSB first. The operands are loaded into shift
//           registers on accept. Each RUN cycle subtracts the two LSBs and
//           the registered borrow, and shifts the difference bit into the
//           MSB of the result register. After WIDTH cycles the result sits
//           in DONE until the consumer takes it.
//
// Timing  : accept at edge E0; bits are processed at E1..E_WIDTH; out_valid
//           is high after E_WIDTH. One result completes every WIDTH+2
//           cycles when out_ready is held high.
//
// Parameters:
//   WIDTH  - operand / result width in bits (minimum 2)
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset; aborts any operation in flight
//   bus    - serial_subtractor_if.slave: request (in_valid/in_ready/a/b)
//            and result (out_valid/out_ready/diff/borrow/ovf) handshakes
//
// Configuration:
//   SERIAL_SUBTRACTOR_OVF_EN - when defined, the operand sign bits are
//   captured at load and ovf reports signed overflow in DONE. When
//   undefined, ovf is constant 0 and no extra flops exist.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [STATE_W-1:0] ST_IDLE = IDLE;
  localparam logic [STATE_W-1:0] ST_RUN  = RUN;
  localparam logic [STATE_W-1:0] ST_DONE = DONE;

  // Counter value during the cycle that processes the MSB.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [STATE_W-1:0] state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   diff_q;
  logic               bin;     // registered borrow, becomes the next bit's borrow-in
  logic [CW-1:0]      cnt;

  // ---------------------------------------------------------------------------
  // Full-subtract step: a0 - b0 - bin from two half subtractors.
  // The first cell handles a0 - b0. The second cell subtracts the incoming
  // borrow from that partial difference. A borrow from either cell
  // propagates.
  // ---------------------------------------------------------------------------
  logic d_ab;
  logic bo_ab;
  logic d_bit;
  logic bo_in;
  logic bout;

  half_subtractor u_hs_ab (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .d  (d_ab),
    .bo (bo_ab)
  );

  half_subtractor u_hs_bin (
    .x  (d_ab),
    .y  (bin),
    .d  (d_bit),
    .bo (bo_in)
  );

  assign bout = bo_ab | bo_in;

  // ---------------------------------------------------------------------------
  // Control FSM and serial datapath
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments make every flop sample pre-edge values, so
  // the shift registers and the borrow flop advance in lock-step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      // NOTE: the datapath registers are reset as well as the FSM. An
      // aborted operation must leave diff/borrow at 0, not at a partial
      // result.
      a_sh   <= '0;
      b_sh   <= '0;
      diff_q <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // diff_q is left alone here, so the previous result stays readable.
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // LSB-first results enter at the MSB. After WIDTH shifts, bit 0 of
          // the difference has reached diff_q[0].
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          bin    <= bout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end

        // NOTE: the default branch steers the unused encoding back to IDLE
        // and keeps the case complete.
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.diff      = diff_q;
  // After the MSB step the borrow flop holds the unsigned borrow of a - b.
  assign bus.borrow    = bin;

  // ---------------------------------------------------------------------------
  // Signed overflow (optional)
  // ---------------------------------------------------------------------------
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (state == ST_IDLE && bus.in_valid) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end
  end

  // a - b can only overflow when the operand signs differ. It overflows when
  // the result sign differs from the minuend's sign.
  assign bus.ovf = (state == ST_DONE) &&
                   (a_msb != b_msb) &&
                   (diff_q[WIDTH-1] != a_msb);
`else
  assign bus.ovf = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_state_legal : assert property (
    @(posedge clk) disable iff (!rst_n) state != 2'd3
  );

  // A stalled result must stay valid and unchanged until it is taken.
  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.diff) && $stable(bus.borrow))
  );

endmodule : serial_subtractor
